// File: rtl/note_pkg.sv
// Shared types and constants for the per-lane note lookahead.
package note_pkg;

  localparam int unsigned TIME_W   = 14;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned TYPE_MSB = 15;
  localparam int unsigned TYPE_LSB = 14;
  localparam int unsigned TIME_MSB = 13;
  localparam int unsigned TIME_LSB = 0;

  typedef enum logic [1:0] {
    NT_TAP    = 2'b00,
    NT_HOLD_S = 2'b01,
    NT_HOLD_E = 2'b10,
    NT_END    = 2'b11
  } note_type_e;

  typedef struct packed {
    note_type_e          ntype;
    logic [TIME_W-1:0]   ntime;
  } note_t;

  // Lookahead FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Split a raw chart ROM word into its type and timestamp fields.
  function automatic note_t word_to_note(input logic [WORD_W-1:0] w);
    note_t n;
    n.ntype = note_type_e'(w[TYPE_MSB:TYPE_LSB]);
    n.ntime = w[TIME_MSB:TIME_LSB];
    return n;
  endfunction

endpackage

// File: rtl/note_shift_window.sv
// Ordered note window: push at the tail, pop at the head, slot 0 is earliest.
module note_shift_window
  import note_pkg::*;
#(
  parameter int unsigned WINDOW = 4
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            i_flush,
  input  logic                            i_push,
  input  note_t                           i_push_note,
  input  logic                            i_pop,
  output logic [WINDOW-1:0]               o_valid,
  output note_t [WINDOW-1:0]              o_slot,
  output logic [$clog2(WINDOW+1)-1:0]     o_count
);

  localparam int unsigned CNT_W = $clog2(WINDOW + 1);
  localparam int unsigned IDX_W = $clog2(WINDOW);

  logic [WINDOW-1:0]  r_valid;
  note_t [WINDOW-1:0] r_slot;
  logic [CNT_W-1:0]   r_count;

  logic               w_pop;
  logic               w_push;
  logic [CNT_W-1:0]   w_base;
  logic [IDX_W-1:0]   w_idx;

  // A pop frees the tail first, so a same-cycle push lands one slot lower.
  assign w_pop  = i_pop && (r_count != '0);
  assign w_base = w_pop ? (r_count - CNT_W'(1)) : r_count;
  assign w_push = i_push && (w_base < CNT_W'(WINDOW));
  assign w_idx  = w_base[IDX_W-1:0];

  // Shift toward slot 0 on pop, then write the tail slot on push.
  always_ff @(posedge Clk) begin
    if (Reset || i_flush) begin
      r_valid <= '0;
      r_slot  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_slot  <= {note_t'('0), r_slot[WINDOW-1:1]};
        r_valid <= {1'b0, r_valid[WINDOW-1:1]};
      end
      if (w_push) begin
        r_slot[w_idx]  <= i_push_note;
        r_valid[w_idx] <= 1'b1;
      end
      r_count <= w_base + CNT_W'(w_push);
    end
  end

  assign o_valid = r_valid;
  assign o_slot  = r_slot;
  assign o_count = r_count;

endmodule

// File: rtl/note_lookahead.sv
// Per-lane chart streamer: fetches notes into a lookahead window, expires late
// notes as misses and silently drops hold ends whose hold start was missed.
module note_lookahead
  import note_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned NUM_NOTES = 256,
  parameter int unsigned WINDOW    = 4,
  parameter int unsigned MISS_LATE = 9
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         start,
  input  logic [TIME_W-1:0]            song_frame,
  input  logic                         consume,
  output logic [ADDR_W-1:0]            rom_addr,
  input  logic [WORD_W-1:0]            rom_data,
  output logic [WINDOW-1:0]            win_valid,
  output logic [WINDOW-1:0][1:0]       win_type,
  output logic [WINDOW-1:0][TIME_W-1:0] win_time,
  output logic                         miss_pulse,
  output logic [1:0]                   miss_type,
  output logic                         done
);

  localparam int unsigned CNT_W = $clog2(WINDOW + 1);
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned PTR_W = $clog2(NUM_NOTES + 1);
  localparam int unsigned SUM_W = TIME_W + 1;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [PTR_W-1:0]   r_ptr;
  logic               r_rd_pend;
  logic               r_end_seen;
  logic               r_drop_hold;
  logic               r_miss_pulse;
  logic [1:0]         r_miss_type;
  logic               r_done;

  logic [WINDOW-1:0]  w_valid;
  note_t [WINDOW-1:0] w_slot;
  logic [CNT_W-1:0]   w_count;
  note_t              w_head;
  note_t              w_ret_note;
  logic               w_active;
  logic               w_ret;
  logic               w_sentinel;
  logic               w_push;
  logic               w_issue;
  logic [OCC_W-1:0]   w_occ;
  logic [SUM_W-1:0]   w_late_lim;
  logic               w_expired;
  logic               w_hold_skip;
  logic               w_hit;
  logic               w_miss;
  logic               w_pop;

  assign w_active   = (r_state == ST_FILL) || (r_state == ST_RUN);
  assign w_head     = w_slot[0];
  assign w_ret_note = word_to_note(rom_data);

  // Data return: sentinel ends the chart; anything after the end is discarded.
  assign w_ret      = r_rd_pend && w_active;
  assign w_sentinel = w_ret && (w_ret_note.ntype == NT_END);
  assign w_push     = w_ret && !w_sentinel && !r_end_seen && !start;

  // Each outstanding read holds a slot so the window can never overflow.
  assign w_occ   = OCC_W'(w_count) + OCC_W'(r_rd_pend);
  assign w_issue = w_active && !r_end_seen && !w_sentinel &&
                   (r_ptr < PTR_W'(NUM_NOTES)) && (w_occ < OCC_W'(WINDOW));

  // Late limit is formed one bit wider so large timestamps never wrap.
  assign w_late_lim = SUM_W'(w_head.ntime) + SUM_W'(MISS_LATE);
  assign w_expired  = (r_state == ST_RUN) && w_valid[0] &&
                      (SUM_W'(song_frame) > w_late_lim);

  // One pop per cycle: orphan hold end first, then judge hit, then expiry.
  assign w_hold_skip = w_active && r_drop_hold && w_valid[0] &&
                       (w_head.ntype == NT_HOLD_E);
  assign w_hit       = w_active && consume && w_valid[0] && !w_hold_skip;
  assign w_miss      = w_expired && !w_hit && !w_hold_skip;
  assign w_pop       = w_hold_skip || w_hit || w_miss;

  note_shift_window #(
    .WINDOW (WINDOW)
  ) u_window (
    .Clk         (Clk),
    .Reset       (Reset),
    .i_flush     (start),
    .i_push      (w_push),
    .i_push_note (w_ret_note),
    .i_pop       (w_pop),
    .o_valid     (w_valid),
    .o_slot      (w_slot),
    .o_count     (w_count)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start restarts the chart from any state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: begin
        if ((w_count == CNT_W'(WINDOW)) || r_end_seen) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_end_seen && (w_count == '0) && !r_rd_pend) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = r_state;
    endcase
    if (start) begin
      w_state_nxt = ST_FILL;
    end
  end

  // Fetch pointer, end tracking, hold-drop flag and registered miss/done.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ptr        <= '0;
      r_rd_pend    <= 1'b0;
      r_end_seen   <= 1'b0;
      r_drop_hold  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_miss_type  <= 2'b00;
      r_done       <= 1'b0;
    end else if (start) begin
      r_ptr        <= '0;
      r_rd_pend    <= 1'b0;
      r_end_seen   <= 1'b0;
      r_drop_hold  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_rd_pend <= w_issue;
      if (w_issue) begin
        r_ptr <= r_ptr + PTR_W'(1);
      end
      if (w_sentinel || (w_active && (r_ptr == PTR_W'(NUM_NOTES)))) begin
        r_end_seen <= 1'b1;
      end
      if (w_hold_skip) begin
        r_drop_hold <= 1'b0;
      end else if (w_miss && (w_head.ntype == NT_HOLD_S)) begin
        r_drop_hold <= 1'b1;
      end
      r_miss_pulse <= w_miss;
      if (w_miss) begin
        r_miss_type <= w_head.ntype;
      end
      r_done <= (w_state_nxt == ST_DONE);
    end
  end

  // Window slots are already registered inside the shift window.
  for (genvar g = 0; g < WINDOW; g++) begin : g_out
    assign win_type[g] = w_slot[g].ntype;
    assign win_time[g] = w_slot[g].ntime;
  end

  assign rom_addr   = ADDR_W'(r_ptr);
  assign win_valid  = w_valid;
  assign miss_pulse = r_miss_pulse;
  assign miss_type  = r_miss_type;
  assign done       = r_done;

endmodule
